imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream instruction-memory loader for the single-cycle RISC-V core. It accepts a program as a little-endian byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit word. It writes each word to consecutive instruction-memory addresses and holds the core in reset while loading. It screens every written word's opcode against the set the main decoder supports, so software sees unsupported instructions before the core runs.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load session
- byte_valid  input  1  byte_data/byte_last valid
- byte_data  input  8  program byte, little-endian order
- byte_last  input  1  final byte of program, qualified by byte_valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address of write
- mem_wdata  output  32  packed instruction word
- core_hold  output  1  holds the core in reset while loading
- done  output  1  load session finished (level)
- overflow  output  1  program exceeded capacity (sticky per session)
- illegal  output  1  at least one unsupported opcode written (sticky per session)
- illegal_addr  output  ADDR_W  address of first unsupported word
- word_count  output  ADDR_W+1  words written this session

## Operation
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered.
- Reset values: state IDLE. All outputs 0, including mem_addr, mem_wdata, illegal_addr and word_count.
- IDLE/DONE: byte_ready=0, core_hold=0. When start=1, the next state is LOAD. On that transition, clear done, overflow, illegal, illegal_addr, word_count, the byte index and the pack register.
- LOAD: byte_ready=1, core_hold=1.
  - A byte transfers when byte_valid and byte_ready are both 1.
  - The byte goes into lane byte_idx; lane 0 is bits 7:0.
  - byte_idx increments modulo 4.
- Word completion: the word completes when the lane-3 byte is accepted, or when byte_last is accepted in any lane. On a byte_last partial word, unwritten upper lanes are 0.
- On word completion the next state is WRITE. Latch last_seen = byte_last.
- WRITE (exactly one cycle): mem_we=1, byte_ready=0, core_hold=1.
  - mem_addr = word_count[ADDR_W-1:0] and mem_wdata = the packed word.
  - word_count increments at the end of the cycle.
  - Clear the pack register and byte_idx.
- Leaving WRITE:
  - If last_seen, go to DONE.
  - Else, if word_count+1 = 2^ADDR_W, go to DONE with overflow=1. No further bytes are accepted.
  - Else return to LOAD.
- Opcode screen, applied in WRITE to mem_wdata[6:0]. Legal values: 0000011, 0100011, 0110011, 1100011, 0010011, 1101111.
  - Any other value is still written.
  - On the first illegal word, set illegal=1 and capture illegal_addr=mem_addr.
  - Later illegal words do not change illegal_addr.
- DONE: done=1. A new start re-enters LOAD; memory contents are not cleared.
- start while in LOAD or WRITE is ignored.
- byte_valid outside LOAD is ignored and nothing is consumed.
- A program of exactly 2^ADDR_W words with byte_last on the final byte ends with overflow=0.

## Timing
- From start to LOAD is 1 cycle; byte_ready rises the cycle after start.
- Best-case throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- mem_we asserts in the cycle after the completing byte is accepted.
- done asserts in the cycle after the final WRITE cycle.
- core_hold=1 from the cycle after start through the final WRITE cycle inclusive.
- rst_n low in any state immediately forces all outputs to reset values, including mem_we=0 and core_hold=0, with no clock needed. A partial word is discarded.
- Releasing rst_n leaves the block in IDLE; a fresh start is required.

## Test plan
- Stream bytes 13 05 A0 00, 93 05 B0 00 with byte_last on the final byte, no stalls:
  - required: mem_we at addresses 0 and 1 with data 0x00A00513 and 0x00B00593;
  - required: word_count=2, done=1, illegal=0, 5 cycles per word.
- Send 3 bytes 6F 00 00 with byte_last on the third:
  - required: one write of 0x0000006F to address 0, illegal=0, done=1.
- Words 0x00000013, 0x00000073 (ecall), 0x00000037 (lui):
  - required: all three written, illegal=1, illegal_addr=1, word_count=3.
- ADDR_W=2 with 5 words and no byte_last:
  - required: 4 writes to addresses 0-3, then DONE with overflow=1 and word_count=4;
  - required: byte_ready stays 0 with the fifth word's bytes pending.
- Random byte_valid gaps, plus start pulsed mid-LOAD:
  - required: data is packed identically, the start pulse has no effect, and core_hold stays 1 until the last WRITE.
- Drop rst_n after 2 bytes of the second word:
  - required: mem_we, core_hold and word_count go to 0 asynchronously;
  - required: after reset release and a new start, the first write is at address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_last;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   // master: program source that also observes the memory writes
   modport master (
      output byte_valid, byte_data, byte_last,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data, byte_last,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a little-endian byte stream into instruction words and screens opcodes
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   imem_loader_if.slave      bus,
   output logic              core_hold,
   output logic              done,
   output logic              overflow,
   output logic              illegal,
   output logic [ADDR_W-1:0] illegal_addr,
   output logic [ADDR_W:0]   word_count
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t      state;
   logic [1:0]  byte_idx;
   logic [31:0] pack;
   logic        last_seen;
   logic        accept;
   logic [31:0] lane_word;

   function automatic logic opcode_ok(input logic [6:0] op);
      case (op)
         7'b0000011, 7'b0100011, 7'b0110011,
         7'b1100011, 7'b0010011, 7'b1101111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   assign accept    = bus.byte_valid & bus.byte_ready;
   // upper lanes of a short final word stay zero because pack is cleared per word
   assign lane_word = pack | (32'(bus.byte_data) << {byte_idx, 3'b000});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         byte_idx       <= '0;
         pack           <= '0;
         last_seen      <= 1'b0;
         bus.byte_ready <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         core_hold      <= 1'b0;
         done           <= 1'b0;
         overflow       <= 1'b0;
         illegal        <= 1'b0;
         illegal_addr   <= '0;
         word_count     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= LOAD;
                  bus.byte_ready <= 1'b1;
                  core_hold      <= 1'b1;
                  done           <= 1'b0;
                  overflow       <= 1'b0;
                  illegal        <= 1'b0;
                  illegal_addr   <= '0;
                  word_count     <= '0;
                  byte_idx       <= '0;
                  pack           <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (byte_idx == 2'd3 || bus.byte_last) begin
                     state          <= WRITE;
                     bus.byte_ready <= 1'b0;
                     bus.mem_we     <= 1'b1;
                     bus.mem_addr   <= word_count[ADDR_W-1:0];
                     bus.mem_wdata  <= lane_word;
                     last_seen      <= bus.byte_last;
                  end else begin
                     pack     <= lane_word;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            WRITE: begin
               bus.mem_we <= 1'b0;
               word_count <= word_count + 1'b1;
               pack       <= '0;
               byte_idx   <= '0;
               if (!opcode_ok(bus.mem_wdata[6:0]) && !illegal) begin
                  illegal      <= 1'b1;
                  illegal_addr <= bus.mem_addr;
               end
               // the word just written filled the last address when the low bits are all ones
               if (last_seen || (&word_count[ADDR_W-1:0])) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  core_hold <= 1'b0;
                  overflow  <= ~last_seen;
               end else begin
                  state          <= LOAD;
                  bus.byte_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          core_hold, done, overflow, illegal;
   logic [AW-1:0] illegal_addr;
   logic [AW:0]   word_count;

   imem_loader_if #(.ADDR_W(AW)) bus ();

   imem_loader #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus),
      .core_hold    (core_hold),
      .done         (done),
      .overflow     (overflow),
      .illegal      (illegal),
      .illegal_addr (illegal_addr),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   we_cyc[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   exp_addr = 0;
   bit   hold_watch = 1'b0;
   bit   gaps = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_we) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
               check("mem_wdata", bus.mem_wdata, e.data);
            end
         end
         if (hold_watch && !done) check("core_hold_loading", 32'(core_hold), 32'd1);
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_addr = 0;
      hold_watch = 1'b1;
      check("ready_after_start", 32'(bus.byte_ready), 32'd1);
      check("hold_after_start", 32'(core_hold), 32'd1);
      check("done_cleared", 32'(done), 32'd0);
      check("count_cleared", 32'(word_count), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last);
      int n = 0;
      if (gaps) begin
         bus.byte_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = d;
      bus.byte_last  = last;
      forever begin
         @(negedge clk);
         if (bus.byte_ready) begin
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 100) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int nbytes, input bit last, input int start_at);
      wr_t e;
      logic [31:0] m;
      m = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      e.addr = exp_addr % (1 << AW);
      e.data = w & m;
      exp_q.push_back(e);
      exp_addr++;
      for (int i = 0; i < nbytes; i++) begin
         if (i == start_at) begin
            bus.byte_valid = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         send_byte(w[8*i +: 8], last && (i == nbytes - 1));
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", 32'(done), 32'd1);
      hold_watch = 1'b0;
      check("hold_released", 32'(core_hold), 32'd0);
      check("ready_in_done", 32'(bus.byte_ready), 32'd0);
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.byte_last  = 1'b0;
      #12;
      check("rst_ready", 32'(bus.byte_ready), 32'd0);
      check("rst_we", 32'(bus.mem_we), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      check("rst_hold", 32'(core_hold), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_illegal_addr", 32'(illegal_addr), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // two words, back to back
      do_start();
      send_word(32'h00A0_0513, 4, 1'b0, -1);
      send_word(32'h00B0_0593, 4, 1'b1, -1);
      wait_done();
      check("t1_count", 32'(word_count), 32'd2);
      check("t1_illegal", 32'(illegal), 32'd0);
      check("t1_overflow", 32'(overflow), 32'd0);
      check("t1_we_seen", 32'(we_cyc.size()), 32'd2);
      if (we_cyc.size() == 2) check("t1_cycles_per_word", 32'(we_cyc[1] - we_cyc[0]), 32'd5);

      // short final word
      do_start();
      send_word(32'h0000_006F, 3, 1'b1, -1);
      wait_done();
      check("t2_count", 32'(word_count), 32'd1);
      check("t2_illegal", 32'(illegal), 32'd0);

      // unsupported opcodes
      do_start();
      send_word(32'h0000_0013, 4, 1'b0, -1);
      send_word(32'h0000_0073, 4, 1'b0, -1);
      send_word(32'h0000_0037, 4, 1'b1, -1);
      wait_done();
      check("t3_illegal", 32'(illegal), 32'd1);
      check("t3_illegal_addr", 32'(illegal_addr), 32'd1);
      check("t3_count", 32'(word_count), 32'd3);

      // capacity exceeded
      do_start();
      for (int k = 0; k < 4; k++) send_word(32'h0010_0093 + 32'(k << 20), 4, 1'b0, -1);
      wait_done();
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_count", 32'(word_count), 32'd4);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h13;
      repeat (6) begin
         @(negedge clk);
         check("t4_ready_blocked", 32'(bus.byte_ready), 32'd0);
      end
      bus.byte_valid = 1'b0;

      // exactly full, random gaps, stray start mid-word
      gaps = 1'b1;
      do_start();
      send_word(32'h1234_5033, 4, 1'b0, -1);
      send_word(32'h0042_8263, 4, 1'b0, 2);
      send_word(32'h00A1_2023, 4, 1'b0, -1);
      send_word(32'h0080_006F, 4, 1'b1, -1);
      wait_done();
      gaps = 1'b0;
      check("t5_overflow", 32'(overflow), 32'd0);
      check("t5_count", 32'(word_count), 32'd4);
      check("t5_illegal", 32'(illegal), 32'd0);

      // asynchronous reset mid-word
      do_start();
      send_word(32'h0000_0013, 4, 1'b0, -1);
      send_byte(8'h33, 1'b0);
      send_byte(8'h00, 1'b0);
      check("t6_hold_before", 32'(core_hold), 32'd1);
      check("t6_count_before", 32'(word_count), 32'd1);
      hold_watch = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_we_async", 32'(bus.mem_we), 32'd0);
      check("t6_hold_async", 32'(core_hold), 32'd0);
      check("t6_count_async", 32'(word_count), 32'd0);
      check("t6_ready_async", 32'(bus.byte_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("t6_idle_ready", 32'(bus.byte_ready), 32'd0);
      do_start();
      send_word(32'h0000_0033, 4, 1'b1, -1);
      wait_done();
      check("t6_count_after", 32'(word_count), 32'd1);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
